// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width, the canonical NOP and next-PC select encoding.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JALR   = 2'b10
    } pcsrc_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and flush load a bubble, stall holds, otherwise capture fetch.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pcplus4_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pcplus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pcplus4_q, pcplus4_d;
    logic            valid_q, valid_d;

    // Flush beats stall so a redirect squashes a held instruction.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (flush_i) begin
            instr_d   = NOP_INSTR;
            pc_d      = '0;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end else if (!stall_i) begin
            instr_d   = instr_i;
            pc_d      = pc_i;
            pcplus4_d = pcplus4_i;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, next-PC selection (sequential, branch/JAL, JALR) and IF/ID.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic [1:0]      pcsrc_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] immop_e,
    input  logic [XLEN-1:0] aluresult_e,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d,
    output logic            misalign_e
);

    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pcplus4_f;
    logic [XLEN-1:0] target_e;
    logic            redirect_e;

    assign pcplus4_f = pcf_q + 32'd4;

    // Reserved encoding 11 falls through to sequential fetch.
    always_comb begin
        target_e   = pcplus4_f;
        redirect_e = 1'b0;
        case (pcsrc_e)
            PCSRC_BRANCH: begin
                target_e   = pc_e + immop_e;
                redirect_e = 1'b1;
            end
            PCSRC_JALR: begin
                target_e   = aluresult_e & ~32'd1;
                redirect_e = 1'b1;
            end
            default: ;
        endcase
    end

    // A redirect overrides a fetch stall; misalignment is reported, not blocked.
    always_comb begin
        pcf_d = pcf_q;
        if (redirect_e)
            pcf_d = target_e;
        else if (!stall_f)
            pcf_d = pcplus4_f;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pcf_q <= RESET_PC;
        else
            pcf_q <= pcf_d;
    end

    assign misalign_e = redirect_e & target_e[1];
    assign pc_f       = pcf_q;
    assign imem_addr  = pcf_q;

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_i   (stall_d),
        .flush_i   (flush_d),
        .instr_i   (imem_rdata),
        .pc_i      (pcf_q),
        .pcplus4_i (pcplus4_f),
        .instr_o   (instr_d),
        .pc_o      (pc_d),
        .pcplus4_o (pcplus4_d),
        .valid_o   (valid_d)
    );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I pipeline: holds the PC, addresses instruction memory, computes the next PC (sequential, branch/JAL target from the decoded immediate, JALR target), and registers the fetched word into the IF/ID pipeline register. Its `instr_d` output drives the decode stage, including the immediate sign-extender. The resulting `immop`, after passing to execute, returns here as `immop_e` for target generation. Stall, flush and redirect come from the hazard unit and execute stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous reset, active low.
- `imem_addr` out 32: word address to instruction memory, equal to `pc_f`.
- `imem_rdata` in 32: instruction word, combinational read of `imem_addr`.
- `stall_f` in 1: hold PC.
- `stall_d` in 1: hold the IF/ID register.
- `flush_d` in 1: replace the IF/ID contents with a bubble.
- `pcsrc_e` in 2: next-PC select. 00 = PC+4, 01 = `pc_e`+`immop_e` (branch/JAL), 10 = `aluresult_e` & ~1 (JALR), 11 = reserved, treated as 00.
- `pc_e` in 32: PC of the instruction in execute.
- `immop_e` in 32: sign-extended immediate of the instruction in execute.
- `aluresult_e` in 32: rs1+imm from the execute ALU.
- `pc_f` out 32: current fetch PC.
- `instr_d` out 32: registered instruction.
- `pc_d` out 32: registered PC.
- `pcplus4_d` out 32: registered PC+4.
- `valid_d` out 1: IF/ID holds a real instruction.
- `misalign_e` out 1: redirect target not word aligned (combinational).

## Operation
- PC register `pc_f`. Next-value priority:
  1. Reset: load `RESET_PC`.
  2. `pcsrc_e`≠00: load the redirect target. This applies even if `stall_f`=1, because a redirect overrides a stall.
  3. `stall_f`=1: hold.
  4. Otherwise: load `pc_f`+4.
- Arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0. Target additions wrap the same way with no flag.
- JALR target clears bit 0 only. Bit 1 is kept.
- `misalign_e`=1 when `pcsrc_e`≠00 and target[1]=1. The redirect is still taken; the trap unit owns the response.
- IF/ID register update priority:
  1. Reset: bubble.
  2. `flush_d`=1: bubble, even if `stall_d`=1.
  3. `stall_d`=1: hold all four fields.
  4. Otherwise: `instr_d`←`imem_rdata`, `pc_d`←`pc_f`, `pcplus4_d`←`pc_f`+4, `valid_d`←1.
- Bubble: `instr_d`=32'h0000_0013 (addi x0,x0,0), `pc_d`=0, `pcplus4_d`=0, `valid_d`=0.
- No internal knowledge of hazards. The hazard unit asserts `flush_d` on a taken redirect. The block does not self-flush.

## Timing
- Reset values after the first `clk` edge with `rst_n`=0: `pc_f`=`imem_addr`=`RESET_PC`, IF/ID holds a bubble.
- `misalign_e` is combinational only.
- While `rst_n`=0, inputs are ignored. Reset mid-stall or mid-redirect discards all state.
- Fetch latency: the instruction at `pc_f` in cycle N appears on `instr_d` in cycle N+1, provided it is not stalled or flushed.
- Redirect: `pcsrc_e`≠00 in cycle N gives `pc_f`=target in cycle N+1. The target's instruction is in decode in cycle N+2.
- With `stall_f`=`stall_d`=1 and no redirect, every output is stable cycle to cycle.
- Back-to-back redirects in consecutive cycles each take effect the following cycle. The last one wins.

## Structure
- Shared package `riscv_pkg`:
  - `pcsrc_t` enum: PCSRC_PLUS4, PCSRC_BRANCH, PCSRC_JALR.
  - `NOP_INSTR` = 32'h0000_0013.
  - `XLEN` = 32.
- One sub-module, `if_id_reg`: the IF/ID register with stall/flush/reset priority.
- PC register, adders and next-PC mux stay in `fetch_stage`.

## Test plan
- Reset then free-run, with memory returning its address as data: `pc_f` = 0, 4, 8, …; `instr_d` trails by one cycle; `valid_d` is 0 in the first cycle after reset, then 1.
- At `pc_f`=0x10, drive `pcsrc_e`=01, `pc_e`=0x08, `immop_e`=0xFFFF_FFF8 (−8), with `flush_d`=1: next `pc_f`=0x00; next `instr_d`=0x13 with `valid_d`=0.
- JALR with `aluresult_e`=0x0000_1003: `pc_f`→0x1002 and `misalign_e`=1. Repeat with 0x1001: `pc_f`→0x1000 and `misalign_e`=0.
- `stall_f`=`stall_d`=1 for 3 cycles at `pc_f`=0x20: PC and all IF/ID fields are unchanged. Releasing the stall resumes at 0x24.
- Simultaneous `stall_f`=1, `pcsrc_e`=01 (target 0x40), `stall_d`=1, `flush_d`=1: `pc_f`→0x40 and a bubble is loaded into IF/ID.
- `pc_f`=0xFFFF_FFFC, no stall: next `pc_f`=0. Assert `rst_n`=0 during a stall: `pc_f`=`RESET_PC` and a bubble are loaded on the next edge.
